// File: rtl/mono_crt_scanout.sv
// mono_crt_scanout
// Monochrome CRT raster generator for the 16 MHz video domain. With the
// default parameters it produces 512x342 visible pixels inside 720x390 totals.
// It fetches pixel words from a framebuffer over a fixed-latency request port
// and shifts them out MSB-first.
//
// Optional feature macro: MONO_CRT_TEST_PATTERN_EN
//   When defined, this adds the test_pattern input. While it is high, fetches
//   are suppressed and a 1-pixel checkerboard is loaded in their place.
//
// Ports
//   clk_16mhz    in   pixel clock
//   reset        in   synchronous, active-high
//   test_pattern in   (MONO_CRT_TEST_PATTERN_EN only) checkerboard select
//   fetch_req    out  one-cycle word request strobe
//   fetch_xword  out  word index within the visible line
//   fetch_yaddr  out  visible line index
//   fetch_data   in   word data, valid FETCH_LATENCY cycles after fetch_req
//   hsync        out  horizontal sync (asserted level HSYNC_POL)
//   vsync        out  vertical sync (asserted level VSYNC_POL)
//   out          out  serial video, inverted when OUT_INVERT
//   frame_start  out  one-cycle pulse while xscan/yscan sit at 0/0
//   frame_count  out  completed frames, wraps at 256
module mono_crt_scanout #(
   parameter int ACTIVE_WIDTH   = 512,
   parameter int ACTIVE_HEIGHT  = 342,
   parameter int ACTIVE_XOFFSET = 190,
   parameter int ACTIVE_YOFFSET = 48,
   parameter int TOTAL_WIDTH    = 720,
   parameter int TOTAL_HEIGHT   = 390,
   parameter int HSYNC_OFFSET   = 294,
   parameter int VSYNC_OFFSET   = 128,
   parameter int VSYNC_LINES    = 6,
   parameter bit HSYNC_POL      = 1'b0,
   parameter bit VSYNC_POL      = 1'b0,
   parameter int WORD_WIDTH     = 16,
   parameter int FETCH_LATENCY  = 1,
   parameter bit OUT_INVERT     = 1'b1,
   parameter int XW             = 10,
   parameter int YW             = 9
) (
   input  logic                  clk_16mhz,
   input  logic                  reset,
`ifdef MONO_CRT_TEST_PATTERN_EN
   input  logic                  test_pattern,
`endif
   output logic                  fetch_req,
   output logic [XW-1:0]         fetch_xword,
   output logic [YW-1:0]         fetch_yaddr,
   input  logic [WORD_WIDTH-1:0] fetch_data,
   output logic                  hsync,
   output logic                  vsync,
   output logic                  out,
   output logic                  frame_start,
   output logic [7:0]            frame_count
);

   localparam logic [XW-1:0] X_LAST     = XW'(TOTAL_WIDTH - 1);
   localparam logic [YW-1:0] Y_LAST     = YW'(TOTAL_HEIGHT - 1);
   localparam logic [XW-1:0] X_HS_OFF   = XW'(HSYNC_OFFSET);
   localparam logic [XW-1:0] X_VS_EDGE  = XW'(VSYNC_OFFSET);
   localparam logic [YW-1:0] Y_VS_END   = YW'(VSYNC_LINES);
   localparam logic [XW-1:0] X_ACT_OFF  = XW'(ACTIVE_XOFFSET);
   localparam logic [YW-1:0] Y_ACT_OFF  = YW'(ACTIVE_YOFFSET);
   localparam logic [XW-1:0] X_ACT_W    = XW'(ACTIVE_WIDTH);
   localparam logic [YW-1:0] Y_ACT_H    = YW'(ACTIVE_HEIGHT);
   localparam logic [XW-1:0] X_WORD     = XW'(WORD_WIDTH);
   // fetch_req is registered, so the request slot is decoded one cycle early.
   localparam logic [XW-1:0] X_FETCH0   = XW'(ACTIVE_XOFFSET - FETCH_LATENCY - 2);
   // The word is loaded in the cycle before its first pixel is visible.
   localparam logic [XW-1:0] X_LOAD0    = XW'(ACTIVE_XOFFSET - 1);

   logic [XW-1:0]         xscan;
   logic [YW-1:0]         yscan;
   logic [XW-1:0]         xaddr;
   logic [YW-1:0]         yaddr;
   logic [XW-1:0]         fetch_rel;
   logic [XW-1:0]         load_rel;
   logic [XW-1:0]         fetch_k;
   logic                  x_wrap;
   logic                  y_wrap;
   logic                  line_vis;
   logic                  pix_vis;
   logic                  fetch_hit;
   logic                  fetch_en;
   logic                  load_hit;
   logic [WORD_WIDTH-1:0] load_word;
   logic [WORD_WIDTH-1:0] shift;

   // xaddr/yaddr are unsigned. Positions left of or above the window wrap to
   // large values and fail the range compare, so one compare per axis is enough.
   always_comb begin
      x_wrap    = (xscan == X_LAST);
      y_wrap    = (yscan == Y_LAST);
      xaddr     = xscan - X_ACT_OFF;
      yaddr     = yscan - Y_ACT_OFF;
      line_vis  = (yaddr < Y_ACT_H);
      pix_vis   = line_vis && (xaddr < X_ACT_W);
      fetch_rel = xscan - X_FETCH0;
      fetch_k   = fetch_rel / X_WORD;
      fetch_hit = line_vis && (fetch_rel < X_ACT_W) && ((fetch_rel % X_WORD) == '0);
      load_rel  = xscan - X_LOAD0;
      load_hit  = line_vis && (load_rel < X_ACT_W) && ((load_rel % X_WORD) == '0);
   end

`ifdef MONO_CRT_TEST_PATTERN_EN
   localparam logic [WORD_WIDTH-1:0] TP_WORD = {(WORD_WIDTH/2){2'b10}};

   // test_pattern is sampled per word, so the image can switch at word boundaries.
   always_comb begin
      fetch_en  = fetch_hit && !test_pattern;
      load_word = fetch_data;
      if (test_pattern) begin
         load_word = yaddr[0] ? ~TP_WORD : TP_WORD;
      end
   end
`else
   always_comb begin
      fetch_en  = fetch_hit;
      load_word = fetch_data;
   end
`endif

   always_ff @(posedge clk_16mhz) begin
      if (reset) begin
         xscan       <= '0;
         yscan       <= '0;
         hsync       <= ~HSYNC_POL;
         vsync       <= ~VSYNC_POL;
         out         <= OUT_INVERT;
         fetch_req   <= 1'b0;
         fetch_xword <= '0;
         fetch_yaddr <= '0;
         frame_start <= 1'b0;
         frame_count <= 8'd0;
         shift       <= '0;
      end else begin
         xscan <= x_wrap ? '0 : xscan + 1'b1;
         if (x_wrap) begin
            yscan <= y_wrap ? '0 : yscan + 1'b1;
         end

         if (xscan == X_HS_OFF) begin
            hsync <= ~HSYNC_POL;
         end else if (xscan == '0) begin
            hsync <= HSYNC_POL;
         end

         if (xscan == X_VS_EDGE) begin
            if (yscan == Y_VS_END) begin
               vsync <= ~VSYNC_POL;
            end else if (yscan == '0) begin
               vsync <= VSYNC_POL;
            end
         end

         fetch_req <= fetch_en;
         if (fetch_en) begin
            fetch_xword <= fetch_k;
            fetch_yaddr <= yaddr;
         end

         shift <= load_hit ? load_word : {shift[WORD_WIDTH-2:0], 1'b0};
         out   <= pix_vis ? (shift[WORD_WIDTH-1] ^ OUT_INVERT) : OUT_INVERT;

         // The pulse coincides with the counters sitting at 0/0 after a wrap.
         // It does not fire on the first cycle out of reset.
         frame_start <= x_wrap && y_wrap;
         if (x_wrap && y_wrap) begin
            frame_count <= frame_count + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_mono_crt_scanout.sv
`timescale 1ns/1ps
module tb_mono_crt_scanout;

   localparam int AW  = 32;
   localparam int AH  = 4;
   localparam int XO  = 10;
   localparam int YO  = 3;
   localparam int TW  = 60;
   localparam int TH  = 10;
   localparam int HSO = 20;
   localparam int VSO = 8;
   localparam int VSL = 2;
   localparam int FR  = TW * TH;
   localparam int W1  = 16;
   localparam int L1  = 1;
   localparam int W2  = 8;
   localparam int L2  = 3;

   logic          clk_16mhz = 1'b0;
   logic          reset = 1'b1;
`ifdef MONO_CRT_TEST_PATTERN_EN
   logic          test_pattern = 1'b0;
`endif
   logic          fetch_req1, fetch_req2;
   logic [9:0]    fetch_xword1, fetch_xword2;
   logic [8:0]    fetch_yaddr1, fetch_yaddr2;
   logic [W1-1:0] fetch_data1;
   logic [W2-1:0] fetch_data2;
   logic          hsync1, hsync2, vsync1, vsync2, out1, out2;
   logic          frame_start1, frame_start2;
   logic [7:0]    frame_count1, frame_count2;

   int checks = 0;
   int errors = 0;
   int n = 0;

   always #5 clk_16mhz = ~clk_16mhz;

   mono_crt_scanout #(
      .ACTIVE_WIDTH(AW), .ACTIVE_HEIGHT(AH), .ACTIVE_XOFFSET(XO), .ACTIVE_YOFFSET(YO),
      .TOTAL_WIDTH(TW), .TOTAL_HEIGHT(TH), .HSYNC_OFFSET(HSO), .VSYNC_OFFSET(VSO),
      .VSYNC_LINES(VSL), .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .WORD_WIDTH(W1),
      .FETCH_LATENCY(L1), .OUT_INVERT(1'b1), .XW(10), .YW(9)
   ) dut1 (
      .clk_16mhz(clk_16mhz), .reset(reset),
`ifdef MONO_CRT_TEST_PATTERN_EN
      .test_pattern(test_pattern),
`endif
      .fetch_req(fetch_req1), .fetch_xword(fetch_xword1), .fetch_yaddr(fetch_yaddr1),
      .fetch_data(fetch_data1), .hsync(hsync1), .vsync(vsync1), .out(out1),
      .frame_start(frame_start1), .frame_count(frame_count1)
   );

   mono_crt_scanout #(
      .ACTIVE_WIDTH(AW), .ACTIVE_HEIGHT(AH), .ACTIVE_XOFFSET(XO), .ACTIVE_YOFFSET(YO),
      .TOTAL_WIDTH(TW), .TOTAL_HEIGHT(TH), .HSYNC_OFFSET(HSO), .VSYNC_OFFSET(VSO),
      .VSYNC_LINES(VSL), .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .WORD_WIDTH(W2),
      .FETCH_LATENCY(L2), .OUT_INVERT(1'b0), .XW(10), .YW(9)
   ) dut2 (
      .clk_16mhz(clk_16mhz), .reset(reset),
`ifdef MONO_CRT_TEST_PATTERN_EN
      .test_pattern(test_pattern),
`endif
      .fetch_req(fetch_req2), .fetch_xword(fetch_xword2), .fetch_yaddr(fetch_yaddr2),
      .fetch_data(fetch_data2), .hsync(hsync2), .vsync(vsync2), .out(out2),
      .frame_start(frame_start2), .frame_count(frame_count2)
   );

   // Reference image: an arbitrary but irregular pixel function.
   function automatic bit pix(int x, int y);
      return ((x * 5 + y * 3 + x / 3) % 7) > 3;
   endfunction

   function automatic logic [15:0] mem_word(int k, int y, int w);
      logic [15:0] r;
      r = '0;
      for (int i = 0; i < w; i++) r[w-1-i] = pix(k * w + i, y);
      return r;
   endfunction

   // Framebuffer models: each request is answered exactly FETCH_LATENCY cycles later.
   // Outside that slot the bus carries a recognisable garbage word.
   logic       pv1 = 1'b0;
   int         px1 = 0, py1 = 0;
   logic [2:0] pv2 = 3'b000;
   int         px2 [3];
   int         py2 [3];
   logic [15:0] w1_tmp, w2_tmp;

   always @(posedge clk_16mhz) begin
      pv1    <= fetch_req1;
      px1    <= int'(fetch_xword1);
      py1    <= int'(fetch_yaddr1);
      pv2    <= {pv2[1:0], fetch_req2};
      px2[0] <= int'(fetch_xword2);
      py2[0] <= int'(fetch_yaddr2);
      px2[1] <= px2[0];
      py2[1] <= py2[0];
      px2[2] <= px2[1];
      py2[2] <= py2[1];
   end

   always_comb begin
      w1_tmp      = mem_word(px1, py1, W1);
      w2_tmp      = mem_word(px2[2], py2[2], W2);
      fetch_data1 = pv1 ? w1_tmp : 16'hC5A3;
      fetch_data2 = pv2[2] ? w2_tmp[7:0] : 8'h5C;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk_16mhz);
      checks++;
      if ({hsync1, vsync1, out1, fetch_req1, frame_start1, fetch_xword1, fetch_yaddr1, frame_count1}
          !== {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 9'd0, 8'd0}) begin
         errors++;
         $display("FAIL reset_dut1: got %b %b %b %b %b %0d %0d %0d expected 1 1 1 0 0 0 0 0",
                  hsync1, vsync1, out1, fetch_req1, frame_start1, fetch_xword1, fetch_yaddr1, frame_count1);
      end
      checks++;
      if ({hsync2, vsync2, out2, fetch_req2, frame_start2, fetch_xword2, fetch_yaddr2, frame_count2}
          !== {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 9'd0, 8'd0}) begin
         errors++;
         $display("FAIL reset_dut2: got %b %b %b %b %b %0d %0d %0d expected 0 0 0 0 0 0 0 0",
                  hsync2, vsync2, out2, fetch_req2, frame_start2, fetch_xword2, fetch_yaddr2, frame_count2);
      end
   endtask

   // Two full frames plus a little. Every output of both instances is checked on every cycle.
   task automatic test_frames();
      int s, xs, ys, xc, yc, xa, ya, yac, lin, fr1, fr2, cnt1, cnt2;
      bit vis, vl, va, e, r1, r2;
      reset = 1'b0;
      n     = 0;
      cnt1  = 0;
      cnt2  = 0;
      repeat (2 * FR + 2) begin
         @(negedge clk_16mhz);
         n++;
         s   = n - 1;
         xs  = s % TW;
         ys  = (s / TW) % TH;
         xc  = n % TW;
         yc  = (n / TW) % TH;
         lin = ys * TW + xs;

         e = (xs < HSO);
         checks++;
         if (hsync1 !== ~e) begin errors++; $display("FAIL hsync1 n=%0d: got %b expected %b", n, hsync1, ~e); end
         checks++;
         if (hsync2 !== e) begin errors++; $display("FAIL hsync2 n=%0d: got %b expected %b", n, hsync2, e); end

         va = (lin >= VSO) && (lin < VSL * TW + VSO);
         checks++;
         if (vsync1 !== ~va) begin errors++; $display("FAIL vsync1 n=%0d: got %b expected %b", n, vsync1, ~va); end
         checks++;
         if (vsync2 !== va) begin errors++; $display("FAIL vsync2 n=%0d: got %b expected %b", n, vsync2, va); end

         xa  = xs - XO;
         ya  = ys - YO;
         vis = (xa >= 0) && (xa < AW) && (ya >= 0) && (ya < AH);
         e   = vis ? pix(xa, ya) : 1'b0;
         checks++;
         if (out1 !== ~e) begin errors++; $display("FAIL out1 n=%0d x=%0d y=%0d: got %b expected %b", n, xa, ya, out1, ~e); end
         checks++;
         if (out2 !== e) begin errors++; $display("FAIL out2 n=%0d x=%0d y=%0d: got %b expected %b", n, xa, ya, out2, e); end

         yac = yc - YO;
         vl  = (yac >= 0) && (yac < AH);
         fr1 = xc - (XO - 1 - L1);
         fr2 = xc - (XO - 1 - L2);
         r1  = vl && (fr1 >= 0) && (fr1 < AW) && (fr1 % W1 == 0);
         r2  = vl && (fr2 >= 0) && (fr2 < AW) && (fr2 % W2 == 0);
         checks++;
         if (fetch_req1 !== r1) begin errors++; $display("FAIL fetch_req1 n=%0d: got %b expected %b", n, fetch_req1, r1); end
         checks++;
         if (fetch_req2 !== r2) begin errors++; $display("FAIL fetch_req2 n=%0d: got %b expected %b", n, fetch_req2, r2); end
         if (r1) begin
            checks++;
            if (fetch_xword1 !== 10'(fr1 / W1) || fetch_yaddr1 !== 9'(yac)) begin
               errors++;
               $display("FAIL fetch_addr1 n=%0d: got %0d/%0d expected %0d/%0d", n, fetch_xword1, fetch_yaddr1, fr1 / W1, yac);
            end
         end
         if (r2) begin
            checks++;
            if (fetch_xword2 !== 10'(fr2 / W2) || fetch_yaddr2 !== 9'(yac)) begin
               errors++;
               $display("FAIL fetch_addr2 n=%0d: got %0d/%0d expected %0d/%0d", n, fetch_xword2, fetch_yaddr2, fr2 / W2, yac);
            end
         end

         if (fetch_req1 === 1'b1) cnt1++;
         if (fetch_req2 === 1'b1) cnt2++;
         if (xc == TW - 1) begin
            checks++;
            if (cnt1 != (vl ? AW / W1 : 0)) begin errors++; $display("FAIL fetch_count1 line=%0d: got %0d expected %0d", yc, cnt1, vl ? AW / W1 : 0); end
            checks++;
            if (cnt2 != (vl ? AW / W2 : 0)) begin errors++; $display("FAIL fetch_count2 line=%0d: got %0d expected %0d", yc, cnt2, vl ? AW / W2 : 0); end
            cnt1 = 0;
            cnt2 = 0;
         end

         e = (n % FR == 0);
         checks++;
         if (frame_start1 !== e || frame_start2 !== e) begin
            errors++;
            $display("FAIL frame_start n=%0d: got %b/%b expected %b", n, frame_start1, frame_start2, e);
         end
         checks++;
         if (frame_count1 !== 8'((n / FR) % 256) || frame_count2 !== 8'((n / FR) % 256)) begin
            errors++;
            $display("FAIL frame_count n=%0d: got %0d/%0d expected %0d", n, frame_count1, frame_count2, (n / FR) % 256);
         end
      end
      checks++;
      if (frame_count1 !== 8'd2) begin errors++; $display("FAIL frame_count_final: got %0d expected 2", frame_count1); end
   endtask

   // Reset lands inside the visible window (line 5, xscan 30) and is held for 3 cycles.
   task automatic test_midline_reset();
      int  guard;
      bit  found;
      guard = 0;
      while (!((n % TW) == 30 && ((n / TW) % TH) == 5) && guard < 2 * FR) begin
         @(negedge clk_16mhz);
         n++;
         guard++;
      end
      checks++;
      if (guard >= 2 * FR) begin errors++; $display("FAIL midline_seek: got timeout expected position reached"); end
      reset = 1'b1;
      repeat (3) begin
         @(negedge clk_16mhz);
         checks++;
         if ({hsync1, vsync1, out1, fetch_req1, frame_start1, fetch_xword1, fetch_yaddr1, frame_count1}
             !== {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 9'd0, 8'd0}) begin
            errors++;
            $display("FAIL midreset_dut1: got %b %b %b %b %b %0d %0d %0d expected 1 1 1 0 0 0 0 0",
                     hsync1, vsync1, out1, fetch_req1, frame_start1, fetch_xword1, fetch_yaddr1, frame_count1);
         end
         checks++;
         if ({hsync2, vsync2, out2, fetch_req2, frame_start2, fetch_xword2, fetch_yaddr2, frame_count2}
             !== {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 9'd0, 8'd0}) begin
            errors++;
            $display("FAIL midreset_dut2: got %b %b %b %b %b %0d %0d %0d expected 0 0 0 0 0 0 0 0",
                     hsync2, vsync2, out2, fetch_req2, frame_start2, fetch_xword2, fetch_yaddr2, frame_count2);
         end
      end
      reset = 1'b0;
      n     = 0;
      found = 1'b0;
      while (!found && n < 2 * FR) begin
         @(negedge clk_16mhz);
         n++;
         if (n == 1) begin
            checks++;
            if (hsync1 !== 1'b0 || out1 !== 1'b1 || frame_start1 !== 1'b0) begin
               errors++;
               $display("FAIL post_release: got hsync=%b out=%b fs=%b expected 0 1 0", hsync1, out1, frame_start1);
            end
         end
         if (frame_start1 === 1'b1) found = 1'b1;
      end
      checks++;
      if (!found || n != FR) begin errors++; $display("FAIL frame_start_after_reset: got cycle %0d expected %0d", n, FR); end
      checks++;
      if (frame_start2 !== 1'b1 || frame_count1 !== 8'd1 || frame_count2 !== 8'd1) begin
         errors++;
         $display("FAIL frame_after_reset: got fs2=%b fc=%0d/%0d expected 1 1/1", frame_start2, frame_count1, frame_count2);
      end
   endtask

`ifdef MONO_CRT_TEST_PATTERN_EN
   task automatic test_test_pattern();
      int  s, xa, ya;
      bit  vis, e;
      test_pattern = 1'b1;
      reset = 1'b1;
      repeat (2) @(negedge clk_16mhz);
      reset = 1'b0;
      n = 0;
      repeat (FR) begin
         @(negedge clk_16mhz);
         n++;
         s   = n - 1;
         xa  = (s % TW) - XO;
         ya  = ((s / TW) % TH) - YO;
         vis = (xa >= 0) && (xa < AW) && (ya >= 0) && (ya < AH);
         e   = vis ? ((xa + ya) % 2 == 0) : 1'b0;
         checks++;
         if (fetch_req1 !== 1'b0 || fetch_req2 !== 1'b0) begin
            errors++;
            $display("FAIL tp_fetch n=%0d: got %b/%b expected 0/0", n, fetch_req1, fetch_req2);
         end
         checks++;
         if (out1 !== ~e || out2 !== e) begin
            errors++;
            $display("FAIL tp_out n=%0d x=%0d y=%0d: got %b/%b expected %b/%b", n, xa, ya, out1, out2, ~e, e);
         end
      end
      test_pattern = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_frames();
      test_midline_reset();
`ifdef MONO_CRT_TEST_PATTERN_EN
      test_test_pattern();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
